// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control FSM with 10 ms prescaler and BCD mm:ss.cc timebase.
// Drives live time, a lap-freezable display value, and a sticky overflow flag.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        lap_clear,
   output logic [23:0] time_bcd,
   output logic [23:0] disp_bcd,
   output logic [1:0]  state,
   output logic        running,
   output logic        tick,
   output logic        overflow
);

   localparam int unsigned PW      = $clog2(TICK_DIV);
   localparam int unsigned NDIG    = 6;
   localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
   // Per-digit rollover limits, digit 0 = centisecond ones.
   localparam logic [NDIG-1:0][3:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_LAP   = 2'd2,
      S_PAUSE = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [23:0]   time_q, time_d;
   logic [23:0]   lap_q, lap_d;
   logic [23:0]   disp_q, disp_d;
   logic          ovf_q, ovf_d;
   logic          tick_q, tick_d;
   logic          run_q, run_d;

   logic [23:0]   inc_val;
   logic          inc_wrap;
   logic          counting;

   // Ripple BCD increment of the live time; inc_wrap flags 99:59.99 rollover.
   always_comb begin : bcd_inc
      logic [NDIG-1:0][3:0] dig;
      logic                 carry;
      dig   = time_q;
      carry = 1'b1;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (carry) begin
            if (dig[3'(i)] == DIGIT_MAX[3'(i)]) begin
               dig[3'(i)] = 4'd0;
            end else begin
               dig[3'(i)] = dig[3'(i)] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
      inc_val  = dig;
      inc_wrap = carry;
   end

   assign counting = (state_q == S_RUN) || (state_q == S_LAP);

   // Next-state: prescaler, timebase, and run-control transitions.
   always_comb begin : next_state
      state_d = state_q;
      pcnt_d  = pcnt_q;
      time_d  = time_q;
      lap_d   = lap_q;
      ovf_d   = ovf_q;
      tick_d  = 1'b0;

      if (counting) begin
         if (pcnt_q == PMAX) begin
            pcnt_d = '0;
            time_d = inc_val;
            tick_d = 1'b1;
            if (inc_wrap) begin
               ovf_d = 1'b1;
            end
         end else begin
            pcnt_d = pcnt_q + PW'(1);
         end
      end

      // start_stop has priority; a simultaneous lap_clear is dropped.
      case (state_q)
         S_IDLE: begin
            if (start_stop) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (start_stop) begin
               state_d = S_PAUSE;
            end else if (lap_clear) begin
               state_d = S_LAP;
               lap_d   = time_d;
            end
         end
         S_LAP: begin
            if (start_stop) begin
               state_d = S_PAUSE;
            end else if (lap_clear) begin
               state_d = S_RUN;
            end
         end
         S_PAUSE: begin
            if (start_stop) begin
               state_d = S_RUN;
            end else if (lap_clear) begin
               state_d = S_IDLE;
               time_d  = '0;
               pcnt_d  = '0;
               lap_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      run_d  = (state_d == S_RUN) || (state_d == S_LAP);
      disp_d = (state_d == S_LAP) ? lap_d : time_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pcnt_q  <= '0;
         time_q  <= '0;
         lap_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         tick_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         time_q  <= time_d;
         lap_q   <= lap_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         tick_q  <= tick_d;
         run_q   <= run_d;
      end
   end

   assign time_bcd = time_q;
   assign disp_bcd = disp_q;
   assign state    = state_q;
   assign running  = run_q;
   assign tick     = tick_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl at TICK_DIV=4: stimulus queues expected
// tick events and per-cycle output values; a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

   localparam int unsigned TD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_stop = 1'b0;
   logic        lap_clear = 1'b0;
   logic [23:0] time_bcd;
   logic [23:0] disp_bcd;
   logic [1:0]  state;
   logic        running;
   logic        tick;
   logic        overflow;

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .lap_clear  (lap_clear),
      .time_bcd   (time_bcd),
      .disp_bcd   (disp_bcd),
      .state      (state),
      .running    (running),
      .tick       (tick),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {F_STATE, F_TIME, F_DISP, F_RUN, F_TICK, F_OVF} field_e;
   typedef struct {
      int          c;
      field_e      f;
      logic [23:0] v;
   } exp_t;
   typedef struct {
      int          c;
      logic [23:0] v;
   } tick_t;

   exp_t  exp_q[$];
   tick_t tick_q[$];
   int    n_checks = 0;
   int    n_pass = 0;
   int    bad_digits = 0;

   function automatic void check(string name, logic [23:0] act, logic [23:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
   endfunction

   function automatic void fail_now(string name, int got, int req);
      n_checks++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, req, cyc);
   endfunction

   // Independent reference: total centiseconds to mm:ss.cc BCD.
   function automatic logic [23:0] cs_to_bcd(int total);
      int t, mins, secs, cs;
      t    = total % 600000;
      mins = t / 6000;
      secs = (t / 100) % 60;
      cs   = t % 100;
      return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
              4'(cs / 10), 4'(cs % 10)};
   endfunction

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(int c, field_e f, logic [23:0] v);
      exp_t e;
      e.c = c; e.f = f; e.v = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_tick(int c, logic [23:0] v);
      tick_t e;
      e.c = c; e.v = v;
      tick_q.push_back(e);
   endtask

   task automatic expect_zero(int c);
      expect_at(c, F_STATE, 24'h0);
      expect_at(c, F_TIME,  24'h0);
      expect_at(c, F_DISP,  24'h0);
      expect_at(c, F_RUN,   24'h0);
      expect_at(c, F_TICK,  24'h0);
      expect_at(c, F_OVF,   24'h0);
   endtask

   // Monitor: consumes tick events and scheduled per-cycle expectations.
   always @(negedge clk) begin
      logic [23:0] act;
      while (tick_q.size() > 0 && tick_q[0].c < cyc && tick !== 1'b1) begin
         fail_now("missed_tick", cyc, tick_q[0].c);
         void'(tick_q.pop_front());
      end
      if (tick === 1'b1) begin
         if (tick_q.size() == 0) begin
            fail_now("unexpected_tick", cyc, -1);
         end else begin
            tick_t t;
            t = tick_q.pop_front();
            check("tick_cycle", 24'(cyc), 24'(t.c));
            check("tick_time", time_bcd, t.v);
         end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].c < cyc) begin
            fail_now("missed_expect", cyc, exp_q[i].c);
            exp_q.delete(i);
         end else if (exp_q[i].c == cyc) begin
            case (exp_q[i].f)
               F_STATE: act = 24'(state);
               F_TIME:  act = time_bcd;
               F_DISP:  act = disp_bcd;
               F_RUN:   act = 24'(running);
               F_TICK:  act = 24'(tick);
               default: act = 24'(overflow);
            endcase
            check(exp_q[i].f.name(), act, exp_q[i].v);
            exp_q.delete(i);
         end
      end
      for (int d = 0; d < 6; d++) begin
         if (time_bcd[4*d +: 4] > 4'd9) bad_digits++;
      end
      if (time_bcd[15:12] > 4'd5) bad_digits++;
   end

   initial begin
      int c0, t10, t6000, p, u, s, s2, s3, s4;

      rst = 1'b1;
      step(3);
      rst = 1'b0;
      expect_zero(cyc);
      lap_clear = 1'b1;
      expect_at(cyc + 1, F_STATE, 24'h0);
      expect_at(cyc + 1, F_DISP,  24'h0);
      step(1);
      lap_clear = 1'b0;

      // Start latency and first increments.
      step(1);
      c0 = cyc;
      start_stop = 1'b1;
      expect_at(c0 + 1, F_STATE, 24'h1);
      expect_at(c0 + 1, F_RUN,   24'h1);
      expect_at(c0 + 4, F_TIME,  24'h0);
      expect_at(c0 + 4, F_TICK,  24'h0);
      for (int k = 1; k <= 12; k++) expect_tick(c0 + 1 + 4 * k, cs_to_bcd(k));
      expect_at(c0 + 5, F_TIME, 24'h000001);
      expect_at(c0 + 9, F_TIME, 24'h000002);
      step(1);
      start_stop = 1'b0;

      // Lap freeze at 00:00.10 and release.
      t10 = c0 + 41;
      step(t10 - cyc);
      lap_clear = 1'b1;
      expect_at(t10 + 1,  F_STATE, 24'h2);
      expect_at(t10 + 1,  F_DISP,  24'h000010);
      expect_at(t10 + 1,  F_RUN,   24'h1);
      expect_at(t10 + 4,  F_DISP,  24'h000010);
      expect_at(t10 + 8,  F_DISP,  24'h000010);
      expect_at(t10 + 8,  F_TIME,  24'h000012);
      step(1);
      lap_clear = 1'b0;
      step(8);
      lap_clear = 1'b1;
      expect_at(t10 + 10, F_STATE, 24'h1);
      expect_at(t10 + 10, F_DISP,  24'h000012);
      expect_at(t10 + 12, F_DISP,  24'h000013);
      step(1);
      lap_clear = 1'b0;

      // Long run through 00:59.99 -> 01:00.00.
      for (int k = 13; k <= 6000; k++) expect_tick(c0 + 1 + 4 * k, cs_to_bcd(k));
      expect_at(c0 + 1 + 4 * 5999, F_TIME, 24'h005999);
      t6000 = c0 + 1 + 4 * 6000;
      expect_at(t6000, F_TIME, 24'h010000);

      // Pause with two cycles of partial tick held, then resume.
      step(t6000 + 1 - cyc);
      start_stop = 1'b1;
      expect_at(t6000 + 2,  F_STATE, 24'h3);
      expect_at(t6000 + 2,  F_RUN,   24'h0);
      expect_at(t6000 + 2,  F_TIME,  24'h010000);
      expect_at(t6000 + 30, F_TIME,  24'h010000);
      expect_at(t6000 + 30, F_TICK,  24'h0);
      expect_at(t6000 + 52, F_TIME,  24'h010000);
      step(1);
      start_stop = 1'b0;
      p = t6000 + 52;
      step(p - cyc);
      start_stop = 1'b1;
      expect_at(p + 1, F_STATE, 24'h1);
      expect_at(p + 2, F_TIME,  24'h010000);
      expect_at(p + 2, F_TICK,  24'h0);
      expect_tick(p + 3, 24'h010001);
      expect_tick(p + 7, 24'h010002);
      step(1);
      start_stop = 1'b0;

      // Simultaneous start_stop + lap_clear in RUN, then clear from PAUSE.
      u = p + 7;
      step(u + 1 - cyc);
      start_stop = 1'b1;
      lap_clear  = 1'b1;
      expect_at(u + 2, F_STATE, 24'h3);
      expect_at(u + 2, F_DISP,  24'h010002);
      expect_at(u + 2, F_TIME,  24'h010002);
      step(1);
      start_stop = 1'b0;
      lap_clear  = 1'b0;
      step(1);
      lap_clear = 1'b1;
      expect_zero(u + 4);
      step(1);
      lap_clear = 1'b0;

      // Preload 09:59.99 while idle, verify carry into minute tens.
      force dut.time_d = 24'h095999;
      step(1);
      release dut.time_d;
      expect_at(cyc, F_TIME,  24'h095999);
      expect_at(cyc, F_STATE, 24'h0);
      s = cyc;
      start_stop = 1'b1;
      expect_tick(s + 5, 24'h100000);
      expect_at(s + 5, F_OVF, 24'h0);
      step(1);
      start_stop = 1'b0;
      step(s + 6 - cyc);
      start_stop = 1'b1;
      step(1);
      start_stop = 1'b0;
      lap_clear  = 1'b1;
      expect_zero(s + 8);
      step(1);
      lap_clear = 1'b0;

      // Preload 99:59.99, wrap sets sticky overflow until cleared.
      force dut.time_d = 24'h995999;
      step(1);
      release dut.time_d;
      s2 = cyc;
      start_stop = 1'b1;
      expect_at(s2 + 1, F_STATE, 24'h1);
      expect_at(s2 + 4, F_OVF,   24'h0);
      expect_at(s2 + 4, F_TIME,  24'h995999);
      expect_tick(s2 + 5, 24'h000000);
      expect_at(s2 + 5, F_OVF,   24'h1);
      expect_tick(s2 + 9, 24'h000001);
      expect_at(s2 + 9, F_OVF,   24'h1);
      step(1);
      start_stop = 1'b0;
      step(s2 + 10 - cyc);
      start_stop = 1'b1;
      expect_at(s2 + 11, F_STATE, 24'h3);
      expect_at(s2 + 11, F_OVF,   24'h1);
      step(1);
      start_stop = 1'b0;
      lap_clear  = 1'b1;
      expect_zero(s2 + 12);
      step(1);
      lap_clear = 1'b0;

      // Lap then reset mid-run with a partial tick pending.
      s3 = cyc;
      start_stop = 1'b1;
      expect_tick(s3 + 5, 24'h000001);
      expect_tick(s3 + 9, 24'h000002);
      step(1);
      start_stop = 1'b0;
      step(s3 + 9 - cyc);
      lap_clear = 1'b1;
      expect_at(s3 + 10, F_STATE, 24'h2);
      expect_at(s3 + 10, F_DISP,  24'h000002);
      step(1);
      lap_clear = 1'b0;
      rst = 1'b1;
      expect_zero(s3 + 12);
      step(1);
      rst = 1'b0;
      step(1);

      // Restart after reset: no partial tick retained.
      s4 = cyc;
      start_stop = 1'b1;
      expect_tick(s4 + 5, 24'h000001);
      step(1);
      start_stop = 1'b0;
      step(8);

      check("leftover_ticks",   24'(tick_q.size()), 24'h0);
      check("leftover_expects", 24'(exp_q.size()),  24'h0);
      check("digit_range",      24'(bad_digits),    24'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
